ones_counter_seq: RTL and testbench
===================================

// Module: ones_counter_seq
// PURPOSE
//  Multi-cycle population counter for a WIDTH-bit word. Counts ones, or zeros in
//  zero mode, CHUNK bits per clock. Uses a valid/ready handshake on input and output.
//  Generalises the fixed 4-bit combinational ones counter. It is the counting
//  engine for wider datapaths where a single-cycle adder tree is too slow.
// PARAMETERS
//  WIDTH  16  bits per input word; must be a multiple of CHUNK (elaboration error otherwise)
//  CHUNK   4  bits counted per clock; NCHUNK = WIDTH/CHUNK count cycles per word
// PORTS
//  clk          in   1      rising-edge clock; the single clock domain
//  rst          in   1      synchronous, active-high reset
//  in_data      in   WIDTH  word to count
//  in_zeros     in   1      1 = count zeros, 0 = count ones; sampled with in_data
//  in_valid     in   1      in_data/in_zeros valid
//  in_ready     out  1      block can accept a word (high only in IDLE)
//  out_count    out  CW     result; CW = $clog2(WIDTH+1) (5 for WIDTH=16)
//  out_all      out  1      every bit matched the counted value (count == WIDTH)
//  out_none     out  1      no bit matched (count == 0)
//  out_parity   out  1      XOR of all in_data bits, independent of in_zeros
//  out_valid    out  1      result valid; held until taken
//  out_ready    in   1      consumer accepts result
//  busy         out  1      high in COUNT or DONE
// BEHAVIOUR
//  Reset: state=IDLE, in_ready=1, out_valid=0, busy=0, out_count=0, out_all=0,
//   out_none=0, out_parity=0. The accumulator, shift register and chunk index clear.
//  FSM states: IDLE, COUNT, DONE. All outputs are registered.
//  IDLE: in_ready=1. On in_valid&&in_ready, latch in_data into the shift register,
//   latch in_zeros, clear the accumulator and chunk index, compute parity, and go to COUNT.
//  COUNT: each edge adds popcount(shreg[CHUNK-1:0]) to acc. The chunk is bitwise
//   inverted first when zeros mode is latched. shreg then shifts right by CHUNK and
//   the index increments. On the edge that processes chunk NCHUNK-1, load
//   out_count/out_all/out_none/out_parity, set out_valid=1, and go to DONE.
//  Latency: out_valid rises exactly NCHUNK edges after the accepting edge
//   (4 for the defaults).
//  DONE: out_* stay stable while out_valid && !out_ready. On the out_valid&&out_ready
//   edge: out_valid=0, go to IDLE. The next word can be accepted on the following
//   edge, so minimum turnaround is NCHUNK+2 cycles per word.
//  in_valid is ignored in COUNT and DONE because in_ready=0. No word is queued.
//  out_ready while out_valid=0 has no effect.
//  Widths: acc is CW bits and cannot overflow (max WIDTH).
//   The per-chunk count is $clog2(CHUNK+1) bits, zero-extended before the add.
//  Reset in any state, including mid-COUNT or DONE with out_valid high, abandons the
//   word. The next cycle shows reset values and no result is emitted.
//  Simultaneous rst and handshake: rst wins.
//  Output ports hold their last values between results, except out_valid.
// STRUCTURE
//  Shared header ones_counter_defs.vh holds: the state encodings
//   (IDLE=2'd0, COUNT=2'd1, DONE=2'd2) and the CW/index-width clog2 helper.
//  Sub-module ones_counter_chunk #(CHUNK): combinational popcount of CHUNK bits,
//   with output width $clog2(CHUNK+1). It generalises the 4-bit counter.
//  The top level holds the FSM, shift register, accumulator, chunk index and output registers.
// TESTING
//  1 defaults, in_data=16'h0000, in_zeros=0 -> out_count=0, out_none=1,
//    out_parity=0, out_valid exactly 4 edges after accept.
//  2 in_data=16'hFFFF, in_zeros=0 -> out_count=16, out_all=1, out_parity=0.
//    Same word with in_zeros=1 -> out_count=0, out_none=1.
//  3 in_data=16'h8001, in_zeros=1 -> out_count=14, out_parity=0.
//    in_data=16'h0007, in_zeros=0 -> out_count=3, out_parity=1.
//  4 out_ready=0 for 6 cycles after out_valid -> out_count/flags stable, in_ready=0,
//    in_valid pulses ignored. out_ready=1 -> out_valid=0 next cycle, in_ready=1.
//  5 rst for one cycle during the 2nd COUNT edge -> next cycle out_valid=0, in_ready=1,
//    busy=0, out_count=0. Then 16'h00F0 -> out_count=4, with no stale result first.
//  6 WIDTH=8, CHUNK=2, in_data=8'b1011_0110 -> out_count=5 after 4 edges.
//    Back-to-back words with out_ready=1 -> one result per word, in order.

Source files
------------

// File: rtl/ones_counter_seq_pkg.sv
// Shared types and width helpers for the sequential population counter.
package ones_counter_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_CHUNK = 4;

  // Bits needed to hold any value in 0..n.
  function automatic int cw_of(input int n);
    return $clog2(n + 1);
  endfunction

  // Bits needed to index n items, never less than one.
  function automatic int idx_w_of(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ones_counter_seq_if.sv
// Input/output handshake bundle of the sequential population counter.
interface ones_counter_seq_if
  import ones_counter_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  localparam int CW = cw_of(WIDTH);

  logic [WIDTH-1:0] in_data;
  logic             in_zeros;
  logic             in_valid;
  logic             in_ready;
  logic [CW-1:0]    out_count;
  logic             out_all;
  logic             out_none;
  logic             out_parity;
  logic             out_valid;
  logic             out_ready;
  logic             busy;

  modport master (
    output in_data, in_zeros, in_valid, out_ready,
    input  in_ready, out_count, out_all, out_none, out_parity, out_valid, busy
  );

  modport slave (
    input  in_data, in_zeros, in_valid, out_ready,
    output in_ready, out_count, out_all, out_none, out_parity, out_valid, busy
  );
endinterface

// File: rtl/ones_counter_seq_chunk.sv
// Combinational popcount of one CHUNK-bit slice.
module ones_counter_chunk
  import ones_counter_seq_pkg::*;
#(
  parameter int CHUNK = DEF_CHUNK,
  localparam int PW   = cw_of(CHUNK)
) (
  input  logic [CHUNK-1:0] bits_i,
  output logic [PW-1:0]    count_o
);

  always_comb begin
    count_o = '0;
    for (int i = 0; i < CHUNK; i++) begin
      count_o = count_o + PW'(bits_i[i]);
    end
  end

endmodule

// File: rtl/ones_counter_seq.sv
// Multi-cycle ones/zeros counter: CHUNK bits per clock, valid/ready on both sides.
module ones_counter_seq
  import ones_counter_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input logic          clk,
  input logic          rst,
  ones_counter_seq_if.slave bus
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = cw_of(WIDTH);
  localparam int PW     = cw_of(CHUNK);
  localparam int IW     = idx_w_of(NCHUNK);

  generate
    if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
      $error("ones_counter_seq: WIDTH must be a positive multiple of CHUNK");
    end
  endgenerate

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             zeros_q, zeros_d;
  logic             par_q, par_d;
  logic [CW-1:0]    acc_q, acc_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [CW-1:0]    count_q, count_d;
  logic             all_q, all_d;
  logic             none_q, none_d;
  logic             parity_q, parity_d;
  logic             valid_q, valid_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;

  logic [CHUNK-1:0] chunk_bits;
  logic [PW-1:0]    chunk_cnt;
  logic [CW-1:0]    sum;

  // Zeros mode counts ones of the inverted slice.
  assign chunk_bits = shreg_q[CHUNK-1:0] ^ {CHUNK{zeros_q}};
  assign sum        = acc_q + CW'(chunk_cnt);

  ones_counter_chunk #(.CHUNK(CHUNK)) u_chunk (
    .bits_i  (chunk_bits),
    .count_o (chunk_cnt)
  );

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    zeros_d  = zeros_q;
    par_d    = par_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    count_d  = count_q;
    all_d    = all_q;
    none_d   = none_q;
    parity_d = parity_q;
    valid_d  = valid_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          shreg_d = bus.in_data;
          zeros_d = bus.in_zeros;
          par_d   = ^bus.in_data;
          acc_d   = '0;
          idx_d   = '0;
          state_d = ST_COUNT;
        end
      end
      ST_COUNT: begin
        acc_d   = sum;
        shreg_d = shreg_q >> CHUNK;
        idx_d   = idx_q + 1'b1;
        if (idx_q == IW'(NCHUNK - 1)) begin
          count_d  = sum;
          all_d    = (sum == CW'(WIDTH));
          none_d   = (sum == '0);
          parity_d = par_q;
          valid_d  = 1'b1;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Status flags follow the next state so they are registered like the rest.
    in_ready_d = (state_d == ST_IDLE);
    busy_d     = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      shreg_q    <= '0;
      zeros_q    <= 1'b0;
      par_q      <= 1'b0;
      acc_q      <= '0;
      idx_q      <= '0;
      count_q    <= '0;
      all_q      <= 1'b0;
      none_q     <= 1'b0;
      parity_q   <= 1'b0;
      valid_q    <= 1'b0;
      in_ready_q <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      zeros_q    <= zeros_d;
      par_q      <= par_d;
      acc_q      <= acc_d;
      idx_q      <= idx_d;
      count_q    <= count_d;
      all_q      <= all_d;
      none_q     <= none_d;
      parity_q   <= parity_d;
      valid_q    <= valid_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.busy       = busy_q;
  assign bus.out_count  = count_q;
  assign bus.out_all    = all_q;
  assign bus.out_none   = none_q;
  assign bus.out_parity = parity_q;
  assign bus.out_valid  = valid_q;

endmodule

// File: tb/tb_ones_counter_seq.sv
// Directed bench for ones_counter_seq: 16/4 and 8/2 instances, scoreboard of expected results.
module tb_ones_counter_seq;
  import ones_counter_seq_pkg::*;

  typedef struct packed {
    logic [4:0] count;
    logic       all;
    logic       none;
    logic       parity;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ones_counter_seq_if #(.WIDTH(16)) b16 ();
  ones_counter_seq_if #(.WIDTH(8))  b8  ();

  ones_counter_seq #(.WIDTH(16), .CHUNK(4)) u16 (.clk(clk), .rst(rst), .bus(b16));
  ones_counter_seq #(.WIDTH(8),  .CHUNK(2)) u8  (.clk(clk), .rst(rst), .bus(b8));

  res_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  bit   sel8     = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic res_t model(input logic [15:0] d, input bit z, input int w);
    res_t r;
    int   cnt = 0;
    logic p   = 1'b0;
    for (int i = 0; i < w; i++) begin
      cnt += int'(d[i] ^ z);
      p    = p ^ d[i];
    end
    r.count  = 5'(cnt);
    r.all    = (cnt == w);
    r.none   = (cnt == 0);
    r.parity = p;
    return r;
  endfunction

  function automatic res_t observe();
    res_t r;
    if (sel8) begin
      r.count = 5'(b8.out_count);
      r.all = b8.out_all; r.none = b8.out_none; r.parity = b8.out_parity;
    end else begin
      r.count = b16.out_count;
      r.all = b16.out_all; r.none = b16.out_none; r.parity = b16.out_parity;
    end
    return r;
  endfunction

  function automatic logic get_valid();    return sel8 ? b8.out_valid : b16.out_valid; endfunction
  function automatic logic get_in_ready(); return sel8 ? b8.in_ready  : b16.in_ready;  endfunction
  function automatic logic get_busy();     return sel8 ? b8.busy      : b16.busy;      endfunction

  task automatic drive(input logic [15:0] d, input bit z, input bit v);
    if (sel8) begin
      b8.in_data = d[7:0]; b8.in_zeros = z; b8.in_valid = v;
    end else begin
      b16.in_data = d; b16.in_zeros = z; b16.in_valid = v;
    end
  endtask

  task automatic set_ready(input bit r);
    if (sel8) b8.out_ready = r; else b16.out_ready = r;
  endtask

  // Called at a negedge in IDLE; returns at the negedge right after the accepting edge.
  task automatic send(input logic [15:0] d, input bit z, input bit expect_result);
    check("in_ready_before_accept", 32'(get_in_ready()), 32'd1);
    drive(d, z, 1'b1);
    @(negedge clk);
    drive(16'h0000, 1'b0, 1'b0);
    if (expect_result) sb_q.push_back(model(d, z, sel8 ? 8 : 16));
    $display("send sel8=%0d data=0x%04h zeros=%0d", sel8, d, z);
  endtask

  // Waits (bounded) for out_valid, checks latency and pops/compares the scoreboard.
  task automatic collect(input string tag, input int lat_exp);
    res_t exp_r, obs_r;
    int   n = 0;
    while (!get_valid() && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'(lat_exp));
    check({tag, "_valid"}, 32'(get_valid()), 32'd1);
    if (sb_q.size() == 0) begin
      check({tag, "_sb_nonempty"}, 32'd0, 32'd1);
    end else begin
      exp_r = sb_q.pop_front();
      obs_r = observe();
      check({tag, "_count"},  32'(obs_r.count),  32'(exp_r.count));
      check({tag, "_all"},    32'(obs_r.all),    32'(exp_r.all));
      check({tag, "_none"},   32'(obs_r.none),   32'(exp_r.none));
      check({tag, "_parity"}, 32'(obs_r.parity), 32'(exp_r.parity));
      $display("result %s count=%0d all=%0d none=%0d parity=%0d latency=%0d",
               tag, obs_r.count, obs_r.all, obs_r.none, obs_r.parity, n);
    end
  endtask

  task automatic take(input string tag, input bit keep_ready);
    set_ready(1'b1);
    @(negedge clk);
    check({tag, "_valid_dropped"}, 32'(get_valid()), 32'd0);
    check({tag, "_in_ready_back"}, 32'(get_in_ready()), 32'd1);
    if (!keep_ready) set_ready(1'b0);
  endtask

  initial begin
    res_t held;
    b16.in_data = '0; b16.in_zeros = 1'b0; b16.in_valid = 1'b0; b16.out_ready = 1'b0;
    b8.in_data  = '0; b8.in_zeros  = 1'b0; b8.in_valid  = 1'b0; b8.out_ready  = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check("rst16_in_ready", 32'(b16.in_ready),  32'd1);
    check("rst16_valid",    32'(b16.out_valid), 32'd0);
    check("rst16_busy",     32'(b16.busy),      32'd0);
    check("rst16_count",    32'(b16.out_count), 32'd0);
    check("rst16_flags",    32'({b16.out_all, b16.out_none, b16.out_parity}), 32'd0);
    check("rst8_in_ready",  32'(b8.in_ready),   32'd1);
    check("rst8_count",     32'(b8.out_count),  32'd0);

    // All-zero word, ones mode
    send(16'h0000, 1'b0, 1'b1);
    check("t1_busy", 32'(get_busy()), 32'd1);
    check("t1_in_ready_low", 32'(get_in_ready()), 32'd0);
    collect("t1", 4);
    take("t1", 1'b0);

    send(16'hFFFF, 1'b0, 1'b1); collect("t2a", 4); take("t2a", 1'b0);
    send(16'hFFFF, 1'b1, 1'b1); collect("t2b", 4); take("t2b", 1'b0);
    send(16'h8001, 1'b1, 1'b1); collect("t3a", 4); take("t3a", 1'b0);
    send(16'h0007, 1'b0, 1'b1); collect("t3b", 4); take("t3b", 1'b0);

    // Output back-pressure with ignored input pulses
    send(16'h0F0F, 1'b0, 1'b1);
    collect("t4", 4);
    held = observe();
    for (int i = 0; i < 6; i++) begin
      drive(16'hAAAA, 1'b0, (i % 2) == 0);
      @(negedge clk);
      check("t4_stall_count", 32'(observe()), 32'(held));
      check("t4_stall_valid", 32'(get_valid()), 32'd1);
      check("t4_stall_in_ready", 32'(get_in_ready()), 32'd0);
    end
    drive(16'h0000, 1'b0, 1'b0);
    take("t4", 1'b0);
    repeat (5) begin
      @(negedge clk);
      check("t4_no_ghost_result", 32'(get_valid()), 32'd0);
    end

    // Reset sampled on the 2nd COUNT edge abandons the word
    send(16'h1234, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_valid",    32'(b16.out_valid), 32'd0);
    check("t5_in_ready", 32'(b16.in_ready),  32'd1);
    check("t5_busy",     32'(b16.busy),      32'd0);
    check("t5_count",    32'(b16.out_count), 32'd0);
    send(16'h00F0, 1'b0, 1'b1); collect("t5", 4); take("t5", 1'b0);

    // Narrow instance, then back-to-back words with out_ready held high
    sel8 = 1'b1;
    send(16'h00B6, 1'b0, 1'b1); collect("t6a", 4); take("t6a", 1'b0);
    set_ready(1'b1);
    send(16'h0001, 1'b0, 1'b1); collect("t6b", 4); take("t6b", 1'b1);
    send(16'h00FF, 1'b0, 1'b1); collect("t6c", 4); take("t6c", 1'b1);
    send(16'h0055, 1'b1, 1'b1); collect("t6d", 4); take("t6d", 1'b0);
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
